// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard detection unit.
package hazard_pkg;
    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } hazard_state_e;

    localparam int ZERO_REG    = 0;
    localparam int DEF_REG_W   = 5;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 64;
endpackage

// File: rtl/hazard_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [width-1:0] count
);
    // Count one per enabled cycle until saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {width{1'b0}};
        end else if (inc && (count != {width{1'b1}})) begin
            count <= count + width'(1);
        end else begin
            count <= count;
        end
    end
endmodule

// File: rtl/hazard_detection_unit.sv
// Pipeline stall/freeze/flush control with saturating event counters and
// a sticky memory-timeout flag.
module hazard_detection_unit
    import hazard_pkg::*;
#(
    parameter int REG_W   = DEF_REG_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             IDEX_MemRead,
    input  logic             EXMEM_MemReq,
    input  logic             Mem_Ready,
    input  logic             EXMEM_BranchTaken,
    input  logic             IFID_UsesRm,
    input  logic             IFID_UsesRn,
    input  logic [REG_W-1:0] IDEX_WriteRegister,
    input  logic [REG_W-1:0] IFID_rm,
    input  logic [REG_W-1:0] IFID_rn,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IDEX_Write,
    output logic             EXMEM_Write,
    output logic             IDEX_Bubble,
    output logic             MEMWB_Bubble,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Flush,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FreezeCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic             MemTimeout
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    hazard_state_e     state_r;
    hazard_state_e     state_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_s;
    logic              timeout_r;
    logic              timeout_s;
    logic              freeze_s;
    logic              flush_s;
    logic              load_use_s;
    logic              rm_hit_s;
    logic              rn_hit_s;

    // Event decode; priority is freeze, then branch flush, then load-use.
    always_comb begin
        freeze_s   = EXMEM_MemReq & ~Mem_Ready;
        flush_s    = EXMEM_BranchTaken & ~freeze_s;
        rm_hit_s   = IFID_UsesRm & (IFID_rm == IDEX_WriteRegister);
        rn_hit_s   = IFID_UsesRn & (IFID_rn == IDEX_WriteRegister);
        load_use_s = ~freeze_s & ~flush_s & IDEX_MemRead
                   & (IDEX_WriteRegister != REG_W'(ZERO_REG))
                   & (rm_hit_s | rn_hit_s);
    end

    // Mealy pipeline controls; all enables drop while in reset.
    always_comb begin
        PCWrite      = 1'b1;
        IFID_Write   = 1'b1;
        IDEX_Write   = 1'b1;
        EXMEM_Write  = 1'b1;
        IDEX_Bubble  = 1'b0;
        MEMWB_Bubble = 1'b0;
        IFID_Flush   = 1'b0;
        IDEX_Flush   = 1'b0;
        EXMEM_Flush  = 1'b0;
        if (!Reset_n) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Write  = 1'b0;
            EXMEM_Write = 1'b0;
        end else if (freeze_s) begin
            PCWrite      = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            EXMEM_Write  = 1'b0;
            MEMWB_Bubble = 1'b1;
        end else if (flush_s) begin
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
        end else if (load_use_s) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end else begin
            PCWrite = 1'b1;
        end
    end

    // Next state and wait-run length; the first frozen cycle counts as one.
    always_comb begin
        state_s    = RUN;
        wait_cnt_s = {WAIT_W{1'b0}};
        if (freeze_s) begin
            state_s = WAIT;
            if (state_r != WAIT) begin
                wait_cnt_s = WAIT_W'(1);
            end else if (wait_cnt_r == WAIT_W'(TIMEOUT)) begin
                wait_cnt_s = wait_cnt_r;
            end else begin
                wait_cnt_s = wait_cnt_r + WAIT_W'(1);
            end
        end else begin
            state_s    = RUN;
            wait_cnt_s = {WAIT_W{1'b0}};
        end
        timeout_s = timeout_r | (freeze_s & (wait_cnt_s == WAIT_W'(TIMEOUT)));
    end

    // State, wait counter and sticky timeout registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r    <= RUN;
            wait_cnt_r <= {WAIT_W{1'b0}};
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            timeout_r  <= timeout_s;
        end
    end

    assign MemTimeout = timeout_r;

    hazard_sat_counter #(.width(CNT_W)) u_stall_cnt (
        .clk(Clk), .rst_n(Reset_n), .inc(load_use_s), .count(StallCount)
    );
    hazard_sat_counter #(.width(CNT_W)) u_freeze_cnt (
        .clk(Clk), .rst_n(Reset_n), .inc(freeze_s), .count(FreezeCount)
    );
    hazard_sat_counter #(.width(CNT_W)) u_flush_cnt (
        .clk(Clk), .rst_n(Reset_n), .inc(flush_s), .count(FlushCount)
    );
endmodule

// File: tb/tb_hazard_detection_unit.sv
// Randomised and directed bench for hazard_detection_unit against an in-bench model.
module tb_hazard_detection_unit;
    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       mr = 1'b0, req = 1'b0, rdy = 1'b0, br = 1'b0, urm = 1'b0, urn = 1'b0;
    logic [4:0] wr = 5'd0, rm = 5'd0, rn = 5'd0;

    logic        b_pcw, b_ifw, b_idw, b_exw, b_idb, b_mwb, b_iff, b_idf, b_exf, b_to;
    logic [15:0] b_stall, b_freeze, b_flush;
    logic        s_pcw, s_ifw, s_idw, s_exw, s_idb, s_mwb, s_iff, s_idf, s_exf, s_to;
    logic [3:0]  s_stall, s_freeze, s_flush;

    int total = 0;
    int bad = 0;

    // model state: raw event counts, current freeze run length, sticky flags
    int m_stall = 0, m_freeze = 0, m_flush = 0, m_run = 0;
    bit m_to_big = 1'b0, m_to_small = 1'b0;

    always #5 Clk = ~Clk;

    hazard_detection_unit dut (
        .Clk(Clk), .Reset_n(Reset_n), .IDEX_MemRead(mr), .EXMEM_MemReq(req),
        .Mem_Ready(rdy), .EXMEM_BranchTaken(br), .IFID_UsesRm(urm), .IFID_UsesRn(urn),
        .IDEX_WriteRegister(wr), .IFID_rm(rm), .IFID_rn(rn),
        .PCWrite(b_pcw), .IFID_Write(b_ifw), .IDEX_Write(b_idw), .EXMEM_Write(b_exw),
        .IDEX_Bubble(b_idb), .MEMWB_Bubble(b_mwb), .IFID_Flush(b_iff), .IDEX_Flush(b_idf),
        .EXMEM_Flush(b_exf), .StallCount(b_stall), .FreezeCount(b_freeze),
        .FlushCount(b_flush), .MemTimeout(b_to)
    );

    hazard_detection_unit #(.REG_W(5), .CNT_W(4), .TIMEOUT(4)) dut_small (
        .Clk(Clk), .Reset_n(Reset_n), .IDEX_MemRead(mr), .EXMEM_MemReq(req),
        .Mem_Ready(rdy), .EXMEM_BranchTaken(br), .IFID_UsesRm(urm), .IFID_UsesRn(urn),
        .IDEX_WriteRegister(wr), .IFID_rm(rm), .IFID_rn(rn),
        .PCWrite(s_pcw), .IFID_Write(s_ifw), .IDEX_Write(s_idw), .EXMEM_Write(s_exw),
        .IDEX_Bubble(s_idb), .MEMWB_Bubble(s_mwb), .IFID_Flush(s_iff), .IDEX_Flush(s_idf),
        .EXMEM_Flush(s_exf), .StallCount(s_stall), .FreezeCount(s_freeze),
        .FlushCount(s_flush), .MemTimeout(s_to)
    );

    wire [8:0] b_vec = {b_pcw, b_ifw, b_idw, b_exw, b_idb, b_mwb, b_iff, b_idf, b_exf};
    wire [8:0] s_vec = {s_pcw, s_ifw, s_idw, s_exw, s_idb, s_mwb, s_iff, s_idf, s_exf};

    localparam logic [8:0] V_RST  = 9'b0000_00_000;
    localparam logic [8:0] V_DEF  = 9'b1111_00_000;
    localparam logic [8:0] V_FRZ  = 9'b0000_01_000;
    localparam logic [8:0] V_FLSH = 9'b1111_00_111;
    localparam logic [8:0] V_LU   = 9'b0011_10_000;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {freeze, flush, load_use} for the current inputs
    function automatic logic [2:0] events();
        logic f, fl, lu;
        f  = req && !rdy;
        fl = br && !f;
        lu = !f && !fl && mr && (wr != 5'd0) && ((urm && rm == wr) || (urn && rn == wr));
        return {f, fl, lu};
    endfunction

    function automatic logic [8:0] exp_vec();
        logic [2:0] e;
        e = events();
        if (!Reset_n) return V_RST;
        if (e[2]) return V_FRZ;
        if (e[1]) return V_FLSH;
        if (e[0]) return V_LU;
        return V_DEF;
    endfunction

    function automatic longint sat(input int v, input int w);
        longint mx;
        mx = (64'sd1 <<< w) - 64'sd1;
        return (v > mx) ? mx : longint'(v);
    endfunction

    // Reference model: advance on each clock, clear on reset.
    always @(posedge Clk or negedge Reset_n) begin
        logic [2:0] e;
        if (!Reset_n) begin
            m_stall = 0; m_freeze = 0; m_flush = 0; m_run = 0;
            m_to_big = 1'b0; m_to_small = 1'b0;
        end else begin
            e = events();
            m_freeze += int'(e[2]);
            m_flush  += int'(e[1]);
            m_stall  += int'(e[0]);
            m_run = e[2] ? m_run + 1 : 0;
            if (m_run >= 64) m_to_big = 1'b1;
            if (m_run >= 4)  m_to_small = 1'b1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        check("ctl_main",   b_vec, exp_vec());
        check("ctl_small",  s_vec, exp_vec());
        check("stall_main", b_stall, sat(m_stall, 16));
        check("frz_main",   b_freeze, sat(m_freeze, 16));
        check("flush_main", b_flush, sat(m_flush, 16));
        check("stall_small", s_stall, sat(m_stall, 4));
        check("frz_small",  s_freeze, sat(m_freeze, 4));
        check("flush_small", s_flush, sat(m_flush, 4));
        check("to_main",    b_to, m_to_big);
        check("to_small",   s_to, m_to_small);
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_in();
        mr = 1'b0; req = 1'b0; rdy = 1'b0; br = 1'b0; urm = 1'b0; urn = 1'b0;
        wr = 5'd0; rm = 5'd0; rn = 5'd0;
    endtask

    task automatic do_reset();
        step();
        Reset_n = 1'b0;
        clear_in();
        step();
        step();
        Reset_n = 1'b1;
    endtask

    initial begin
        clear_in();
        #2;
        check("rst_ctl", b_vec, V_RST);
        check("rst_stall", b_stall, 0);
        check("rst_to", b_to, 0);
        step();
        step();
        Reset_n = 1'b1;

        // load-use hit on rm
        mr = 1'b1; wr = 5'd5; rm = 5'd5; urm = 1'b1;
        #2 check("lu_ctl", b_vec, V_LU);
        step();
        check("lu_cnt", b_stall, 1);
        // destination r0 never stalls
        wr = 5'd0; rm = 5'd0;
        #2 check("lu_r0", b_vec, V_DEF);
        step();
        check("lu_r0_cnt", b_stall, 1);
        // matching but unused rn
        wr = 5'd7; rn = 5'd7; urn = 1'b0; rm = 5'd3;
        #2 check("unused_rn", b_vec, V_DEF);
        step();

        // three-cycle freeze
        do_reset();
        req = 1'b1; rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2 check("frz3_ctl", b_vec, V_FRZ);
            step();
        end
        rdy = 1'b1;
        #2 check("frz3_release", b_vec, V_DEF);
        step();
        check("frz3_cnt", b_freeze, 3);

        // branch held through a two-cycle freeze
        do_reset();
        br = 1'b1; req = 1'b1; rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2 check("br_frz_ctl", b_vec, V_FRZ);
            step();
        end
        rdy = 1'b1;
        #2 check("br_flush_ctl", b_vec, V_FLSH);
        step();
        check("br_flush_cnt", b_flush, 1);

        // counter saturation on the narrow instance
        do_reset();
        mr = 1'b1; wr = 5'd9; rn = 5'd9; urn = 1'b1;
        repeat (20) step();
        check("sat_small", s_stall, 15);
        check("sat_main", b_stall, 20);

        // timeout after TIMEOUT frozen cycles, sticky afterwards
        do_reset();
        req = 1'b1; rdy = 1'b0;
        repeat (63) step();
        check("to_before", b_to, 0);
        step();
        check("to_set", b_to, 1);
        rdy = 1'b1;
        step();
        step();
        check("to_sticky", b_to, 1);

        // reset dropped mid-freeze takes effect without a clock edge
        rdy = 1'b0;
        step();
        step();
        #1 Reset_n = 1'b0;
        #1;
        check("async_ctl", b_vec, V_RST);
        check("async_frz", b_freeze, 0);
        check("async_to", b_to, 0);
        step();
        clear_in();
        Reset_n = 1'b1;
        #2 check("post_rst_ctl", b_vec, V_DEF);
        step();
        check("post_rst_frz", b_freeze, 0);

        // random traffic with small register indices to force matches
        for (int i = 0; i < 600; i++) begin
            mr  = 1'($urandom_range(0, 1));
            req = ($urandom_range(0, 3) == 0);
            rdy = 1'($urandom_range(0, 1));
            br  = ($urandom_range(0, 4) == 0);
            urm = 1'($urandom_range(0, 1));
            urn = 1'($urandom_range(0, 1));
            wr  = 5'($urandom_range(0, 3));
            rm  = 5'($urandom_range(0, 3));
            rn  = 5'($urandom_range(0, 3));
            step();
        end

        @(negedge Clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
